// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared types and constants for the stopwatch core; STOPWATCH_LAP_EN adds the LAP state.
package stopwatch_pkg;
    typedef logic [3:0] bcd_digit_t;
`ifdef STOPWATCH_LAP_EN
    typedef enum logic [1:0] {IDLE, RUN, STOP, LAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
`endif
    localparam int NUM_DIGITS = 6;
    // index 0 is cs_u, index 5 is min_t
    localparam int DIGIT_MOD [NUM_DIGITS] = '{10, 10, 10, 6, 10, 10};
    localparam logic [23:0] BCD_ZERO = '0;
    function automatic bcd_digit_t digit_next(bcd_digit_t q, logic clr, logic inc, bcd_digit_t top);
        return clr ? '0 : !inc ? q : (q == top) ? '0 : q + 4'd1;
    endfunction
endpackage

// File: rtl/bcd_digit_counter.sv
// bcd_digit_counter: one BCD digit rolling over at MOD, with synchronous clear and ripple carry.
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter int MOD = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    output bcd_digit_t q,
    output logic       co
);
    assign co = inc & (q == bcd_digit_t'(MOD - 1));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else q <= digit_next(q, clr, inc, bcd_digit_t'(MOD - 1));
    end
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: mm:ss.cc BCD stopwatch with start/stop/clear FSM; STOPWATCH_LAP_EN enables the lap freeze.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int MIN_LIMIT = 59
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_100hz,
    input  logic        btn_ss,
    input  logic        btn_lc,
    output logic [23:0] bcd,
    output logic        running,
    output logic        lap_frozen,
    output logic        wrap
);
    localparam bcd_digit_t LIM_T = bcd_digit_t'(MIN_LIMIT / 10);
    localparam bcd_digit_t LIM_U = bcd_digit_t'(MIN_LIMIT % 10);
    state_t      state;
    logic        tick_d;
    bcd_digit_t  q [NUM_DIGITS];
    logic [6:0]  ci;
    logic [23:0] live_next;
    logic        counting, clear_cmd, wrap_now, clr;
`ifdef STOPWATCH_LAP_EN
    logic [23:0] lap;
    assign counting = (state == RUN) || (state == LAP);
`else
    assign counting = state == RUN;
    assign lap_frozen = 1'b0;
`endif
    assign ci[0]     = tick_100hz & ~tick_d & counting;
    assign clear_cmd = (state == STOP) & btn_lc & ~btn_ss;
    // ci[6] only fires past 99 minutes, which always means a wrap
    assign wrap_now  = (ci[4] & (q[5] == LIM_T) & (q[4] == LIM_U)) | ci[6];
    assign clr       = clear_cmd | wrap_now;
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_digit_counter #(.MOD(DIGIT_MOD[g])) u_digit (
            .clk  (clk),
            .rst_n(rst_n),
            .clr  (clr),
            .inc  (ci[g]),
            .q    (q[g]),
            .co   (ci[g+1])
        );
        assign live_next[g*4 +: 4] = digit_next(q[g], clr, ci[g], bcd_digit_t'(DIGIT_MOD[g] - 1));
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tick_d  <= 1'b0;
            bcd     <= BCD_ZERO;
            running <= 1'b0;
            wrap    <= 1'b0;
`ifdef STOPWATCH_LAP_EN
            lap_frozen <= 1'b0;
            lap        <= BCD_ZERO;
`endif
        end else begin
            tick_d <= tick_100hz;
            wrap   <= wrap_now;
`ifdef STOPWATCH_LAP_EN
            bcd <= (state == LAP && !btn_ss && !btn_lc) ? lap : live_next;
`else
            bcd <= live_next;
`endif
            case (state)
                IDLE: if (btn_ss) begin
                    state   <= RUN;
                    running <= 1'b1;
                end
                RUN: if (btn_ss) begin
                    state   <= STOP;
                    running <= 1'b0;
                end
`ifdef STOPWATCH_LAP_EN
                else if (btn_lc) begin
                    state      <= LAP;
                    lap_frozen <= 1'b1;
                    lap        <= live_next;
                end
                LAP: if (btn_ss) begin
                    state      <= STOP;
                    running    <= 1'b0;
                    lap_frozen <= 1'b0;
                end else if (btn_lc) begin
                    state      <= RUN;
                    lap_frozen <= 1'b0;
                end
`endif
                STOP: if (btn_ss) begin
                    state   <= RUN;
                    running <= 1'b1;
                end else if (btn_lc) begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed self-checking bench; MIN_LIMIT = 1 keeps the wrap test short.
module tb_stopwatch_ctrl;
    localparam int LIM = 1;
    logic        clk = 1'b0, rst_n = 1'b0, tick = 1'b0, btn_ss = 1'b0, btn_lc = 1'b0;
    logic [23:0] bcd;
    logic        running, lap_frozen, wrap;
    int          n_checks = 0, n_fail = 0, wrap_cnt = 0;

    stopwatch_ctrl #(.MIN_LIMIT(LIM)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_100hz(tick),
        .btn_ss    (btn_ss),
        .btn_lc    (btn_lc),
        .bcd       (bcd),
        .running   (running),
        .lap_frozen(lap_frozen),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (wrap) wrap_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) tick = 1'b1;
            @(negedge clk) tick = 1'b0;
        end
    endtask

    task automatic press(input logic ss, input logic lc);
        @(negedge clk) begin btn_ss = ss; btn_lc = lc; end
        @(negedge clk) begin btn_ss = 1'b0; btn_lc = 1'b0; end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        check("rst_bcd", bcd, 24'h0);
        check("rst_running", running, 0);
        check("rst_lap", lap_frozen, 0);
        check("rst_wrap", wrap, 0);

        press(1, 0);
        check("start_running", running, 1);
        wrap_cnt = 0;
        ticks(150);
        check("count150", bcd, 24'h000150);
        check("count150_running", running, 1);
        check("count150_nowrap", wrap_cnt, 0);

        do_reset();
        press(1, 0);
        ticks(200);
        check("at200", bcd, 24'h000200);
        press(0, 1);
`ifdef STOPWATCH_LAP_EN
        check("lap_enter", lap_frozen, 1);
        check("lap_running", running, 1);
        ticks(30);
        check("lap_frozen_bcd", bcd, 24'h000200);
        check("lap_still", lap_frozen, 1);
        press(0, 1);
        check("lap_exit_bcd", bcd, 24'h000230);
        check("lap_exit", lap_frozen, 0);
`else
        ticks(30);
        check("lc_ignored_bcd", bcd, 24'h000230);
        check("lc_ignored_lap", lap_frozen, 0);
        check("lc_ignored_run", running, 1);
`endif

        press(1, 1);
        check("both_stop", running, 0);
        check("both_nolap", lap_frozen, 0);
        check("both_held", bcd, 24'h000230);
        ticks(5);
        check("stop_held", bcd, 24'h000230);
        press(0, 1);
        check("clear_bcd", bcd, 24'h0);
        check("clear_running", running, 0);
        press(0, 1);
        ticks(3);
        check("idle_lc_ignored", running, 0);
        check("idle_no_count", bcd, 24'h0);

        do_reset();
        press(1, 0);
        ticks(9);
        check("at009", bcd, 24'h000009);
        @(negedge clk) begin tick = 1'b1; btn_ss = 1'b1; end
        @(negedge clk) begin tick = 1'b0; btn_ss = 1'b0; end
        check("coinc_counted", bcd, 24'h000010);
        check("coinc_stop", running, 0);
        ticks(7);
        check("coinc_held", bcd, 24'h000010);
        press(1, 0);
        ticks(1);
        check("resume", bcd, 24'h000011);
        check("resume_running", running, 1);

        do_reset();
        press(1, 0);
        wrap_cnt = 0;
        ticks(LIM * 6000 + 5999);
        check("at_limit", bcd, 24'h015999);
        check("pre_wrap", wrap_cnt, 0);
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
        check("wrap_bcd", bcd, 24'h0);
        check("wrap_high", wrap, 1);
        @(negedge clk);
        check("wrap_low", wrap, 0);
        check("wrap_once", wrap_cnt, 1);
        ticks(1);
        check("post_wrap", bcd, 24'h000001);
        check("post_wrap_run", running, 1);

        ticks(20);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_bcd", bcd, 24'h0);
        check("async_running", running, 0);
        check("async_lap", lap_frozen, 0);
        check("async_wrap", wrap, 0);
        @(negedge clk) rst_n = 1'b1;
        press(0, 1);
        check("after_rst_idle", running, 0);
        press(1, 0);
        ticks(2);
        check("after_rst_run", bcd, 24'h000002);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Centisecond stopwatch core, driven by the 100 Hz square wave from the clock divider and one-cycle button pulses from the debounce/one-pulse stage. It detects each rising edge of the slow tick in the system clock domain and advances a BCD mm:ss.cc count. A start/stop/lap/clear state machine controls the count. The block drives six registered BCD digits to the 7-segment scan stage.

## Interface
- MIN_LIMIT, 59: highest minute value before wrap; legal range 1..99.
- clk  input  1  system clock, 100 MHz.
- rst_n  input  1  asynchronous, active-low reset.
- tick_100hz  input  1  100 Hz square wave from the divider, synchronous to clk.
- btn_ss  input  1  start/stop; one-clk pulse.
- btn_lc  input  1  lap/clear; one-clk pulse.
- bcd  output  24  {min_t, min_u, sec_t, sec_u, cs_t, cs_u}, 4 bits each, registered.
- running  output  1  high in RUN or LAP.
- lap_frozen  output  1  high in LAP.
- wrap  output  1  one-clk pulse when the count wraps to zero.

## Operation
- Tick detection: register tick_d <= tick_100hz. tick_rise = tick_100hz & ~tick_d. Exactly one tick_rise per 100 Hz period.
- Live count: six BCD digits with moduli 10,10,10,6,10,10. Minutes stop at MIN_LIMIT. The count advances by one centisecond on tick_rise only in RUN or LAP.
- Wrap: at MIN_LIMIT:59.99, a tick sets the count to 00:00.00 and pulses wrap for that cycle. Counting continues.
- States: IDLE, RUN, STOP, LAP. Reset enters IDLE with count zero.
- IDLE: btn_ss -> RUN. btn_lc is ignored.
- RUN: btn_ss -> STOP. btn_lc -> LAP and latches the current live count into the lap register.
- LAP: the count keeps running while bcd shows the lap register. btn_lc -> RUN and bcd resumes the live count. btn_ss -> STOP and bcd shows the live count.
- STOP: btn_ss -> RUN, resuming from the held count. btn_lc -> IDLE and clears the count to zero.
- Simultaneous btn_ss and btn_lc: btn_ss wins and btn_lc is dropped.
- Tick in the same cycle as btn_ss in RUN: the tick is counted, then the state becomes STOP.
- Tick in the same cycle as btn_ss in IDLE or STOP: the tick is not counted. The first counted tick is the next one.
- bcd source: the lap register in LAP, otherwise the live count. bcd is registered.

## Timing
- Reset values: bcd = 0, running = 0, lap_frozen = 0, wrap = 0, tick_d = 0, state IDLE.
- tick_100hz rises at edge N (sampled high, tick_d low) -> the live count updates at edge N+1. bcd reflects it at edge N+1, because bcd loads from the next-count value.
- Button pulse at edge N -> state, running and lap_frozen change at edge N+1.
- The lap register captures the count value that includes any tick counted in the same cycle.
- wrap is high for exactly the cycle in which the count shows 00:00.00 after a wrap.
- Asserting rst_n low mid-count clears everything immediately, with no clock needed.

## Configuration
- STOPWATCH_LAP_EN defined: LAP state and lap register exist, as described above.
- STOPWATCH_LAP_EN undefined: no LAP state and no lap register. btn_lc in RUN is ignored. lap_frozen is tied to 0. bcd always shows the live count. btn_lc in STOP still clears to IDLE.

## Structure
- stopwatch_pkg holds:
  - the state enum;
  - the bcd_digit_t 4-bit typedef;
  - digit moduli constants;
  - the BCD zero constant.
- Sub-module bcd_digit_counter: one BCD digit with parameter MOD. Ports are clk, rst_n, clr, inc (carry-in), q, and carry-out, where carry-out = inc & (q == MOD-1). Minutes use a two-digit instance pair, with a MIN_LIMIT compare at the top level.

## Test plan
- Reset, btn_ss, then 150 tick_100hz periods -> bcd = 00:01.50, running = 1, wrap never asserted.
- Preload to MIN_LIMIT:59.99 (default 59) in RUN, then one tick -> bcd = 00:00.00, wrap high for one cycle.
- RUN at 00:02.00, then btn_lc -> bcd frozen at 00:02.00 with lap_frozen = 1 while 30 ticks pass. btn_lc again -> bcd = 00:02.30.
- RUN, then btn_ss and btn_lc in the same cycle -> STOP, lap_frozen = 0, count held. A following btn_lc -> IDLE, bcd = 0.
- btn_ss in RUN coincident with tick_rise at 00:00.09 -> bcd = 00:00.10, then stays fixed in STOP.
- rst_n pulsed low mid-RUN between clk edges -> all outputs 0 immediately, state IDLE.
